// File: rtl/dpath_pn9_pkg.sv
// Shared PN9 (x^9 + x^5 + 1) definitions: FSM states, seed, word widths and
// multi-bit advance functions. sreg[0] holds the newest bit, sreg[8] the oldest.
package dpath_pn9_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } pn9_state_e;

  localparam logic [8:0] PN9_SEED = 9'h1FF;
  localparam int         W16      = 16;
  localparam int         W14      = 14;

  // Next 16 bits of the sequence, first bit in time at the MSB.
  function automatic logic [15:0] pn9_word16(input logic [8:0] sreg);
    logic [8:0]  r;
    logic [15:0] w;
    logic        b;
    r = sreg;
    w = '0;
    for (int i = 0; i < W16; i++) begin
      b = r[8] ^ r[4];
      w = {w[14:0], b};
      r = {r[7:0], b};
    end
    return w;
  endfunction

  // Next 14 bits MSB-justified, two LSBs zero.
  function automatic logic [15:0] pn9_word14(input logic [8:0] sreg);
    logic [8:0]  r;
    logic [13:0] w;
    logic        b;
    r = sreg;
    w = '0;
    for (int i = 0; i < W14; i++) begin
      b = r[8] ^ r[4];
      w = {w[12:0], b};
      r = {r[7:0], b};
    end
    return {w, 2'b00};
  endfunction

  function automatic logic [8:0] pn9_adv16(input logic [8:0] sreg);
    logic [15:0] w;
    w = pn9_word16(sreg);
    return w[8:0];
  endfunction

  function automatic logic [8:0] pn9_adv14(input logic [8:0] sreg);
    logic [15:0] w;
    w = pn9_word14(sreg);
    return w[10:2];
  endfunction

endpackage

// File: rtl/dpath_pn9_pred.sv
// Combinational PN9 predictor: expected next word and next reference state
// for the current reference, in 16-bit (mode=1) or 14-bit (mode=0) framing.
module dpath_pn9_pred
  import dpath_pn9_pkg::*;
(
  input  logic [8:0]  ref_i,
  input  logic        mode_i,
  output logic [15:0] expected_o,
  output logic [8:0]  next_ref_o
);

  always_comb begin
    if (mode_i) begin
      expected_o = pn9_word16(ref_i);
      next_ref_o = pn9_adv16(ref_i);
    end else begin
      expected_o = pn9_word14(ref_i);
      next_ref_o = pn9_adv14(ref_i);
    end
  end

endmodule

// File: rtl/dpath_pn9_chk.sv
// PN9 receive checker: self-seeds from the data, locks, counts bit errors and words.
// Optional bit_cnt output when DPATH_PN9_CHK_BITCNT_EN is defined.
module dpath_pn9_chk
  import dpath_pn9_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_CNT    = 4,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             valid,
  input  logic [15:0]      in,
  input  logic             clr,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] word_cnt,
  output logic             err_word
`ifdef DPATH_PN9_CHK_BITCNT_EN
  ,
  output logic [ERR_W+3:0] bit_cnt
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int SW = ERR_W + 5;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  pn9_state_e       state_q, state_d;
  logic [8:0]       ref_q, ref_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [BW-1:0]    bad_q, bad_d, bad_inc;
  logic             mode_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] word_cnt_q, word_cnt_d;
  logic             err_word_q, err_word_d;

  logic [15:0]      expected;
  logic [8:0]       next_ref;
  logic [8:0]       sreg_rx;
  logic [15:0]      diff;
  logic [4:0]       errs;
  logic             demote;
  logic             count;
  logic [SW-1:0]    err_sum;

  dpath_pn9_pred u_pred (
    .ref_i      (ref_q),
    .mode_i     (mode),
    .expected_o (expected),
    .next_ref_o (next_ref)
  );

  assign sreg_rx  = mode ? in[8:0] : in[10:2];
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);
  // A mode change only matters once we have a reference; in SEARCH the word can seed directly.
  assign demote   = !enable || ((mode != mode_q) && (state_q != SEARCH));

  always_comb begin
    diff = (in ^ expected) & (mode ? 16'hFFFF : 16'hFFFC);
    errs = '0;
    for (int i = 0; i < 16; i++) begin
      errs = errs + 5'(diff[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_word_d = 1'b0;
    count      = 1'b0;
    if (demote) begin
      state_d = SEARCH;
    end else if (valid) begin
      case (state_q)
        SEARCH: begin
          // An all-zero state would lock the LFSR up, so it is never used as a seed.
          if (sreg_rx != 9'd0) begin
            ref_d   = sreg_rx;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          ref_d = next_ref;
          if (errs != 5'd0) begin
            state_d = SEARCH;
          end else begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel on our own prediction so received errors never corrupt the reference.
          ref_d      = next_ref;
          count      = 1'b1;
          err_word_d = (errs != 5'd0);
          if (errs >= 5'(LOSS_THRESH)) begin
            bad_d = bad_inc;
            if (bad_inc == BW'(LOSS_CNT)) begin
              state_d = SEARCH;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    err_sum    = SW'(err_cnt_q) + SW'(errs);
    if (count) begin
      err_cnt_d  = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
      word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + ERR_W'(1);
    end
    if (clr) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      ref_q      <= PN9_SEED;
      good_q     <= '0;
      bad_q      <= '0;
      mode_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      err_word_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      mode_q     <= mode;
      locked_q   <= (state_d == LOCKED);
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_word_q <= err_word_d;
    end
  end

  assign locked   = locked_q;
  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;
  assign err_word = err_word_q;

`ifdef DPATH_PN9_CHK_BITCNT_EN
  localparam int BCW = ERR_W + 4;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [BCW:0]   bit_sum;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    bit_sum   = {1'b0, bit_cnt_q} + (BCW + 1)'(mode ? W16 : W14);
    if (count) begin
      bit_cnt_d = bit_sum[BCW] ? '1 : bit_sum[BCW-1:0];
    end
    if (clr) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule
